// File: rtl/tail_lights_pkg.sv
// Shared types and lamp masks for the dimmed tail-light controller.
// Optional hazard flash is enabled by defining HAZARD_EN.
package tail_lights_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    HAZ  = 3'd7
  } state_t;

  localparam int N_LAMPS = 6;
  localparam int LA_IDX  = 3;
  localparam int RA_IDX  = 2;

  // Left side sweeps toward the MSB, right side toward the LSB.
  localparam logic [N_LAMPS-1:0] MASK_IDLE = 6'b000000;
  localparam logic [N_LAMPS-1:0] MASK_L1   = 6'b000001 << LA_IDX;
  localparam logic [N_LAMPS-1:0] MASK_L2   = 6'b000011 << LA_IDX;
  localparam logic [N_LAMPS-1:0] MASK_L3   = 6'b000111 << LA_IDX;
  localparam logic [N_LAMPS-1:0] MASK_R1   = 6'b000100 >> (2 - RA_IDX);
  localparam logic [N_LAMPS-1:0] MASK_R2   = 6'b000110 >> (2 - RA_IDX);
  localparam logic [N_LAMPS-1:0] MASK_R3   = 6'b000111 >> (2 - RA_IDX);
  localparam logic [N_LAMPS-1:0] MASK_HAZ  = 6'b111111;

  function automatic logic [N_LAMPS-1:0] on_mask(input state_t s);
    logic [N_LAMPS-1:0] m;
    m = MASK_IDLE;
    case (s)
      L1:      m = MASK_L1;
      L2:      m = MASK_L2;
      L3:      m = MASK_L3;
      R1:      m = MASK_R1;
      R2:      m = MASK_R2;
      R3:      m = MASK_R3;
      HAZ:     m = MASK_HAZ;
      default: m = MASK_IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tail_lights_timebase.sv
// Step divider and PWM counter: produces a one-cycle step tick and the
// shared dim-glow enable for all unlit lamps.
module tail_lights_timebase #(
  parameter int STEP_DIV   = 50_000_000,
  parameter int PWM_PERIOD = 16,
  parameter int DIM_DUTY   = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick,
  output logic o_dim
);

  localparam int DW = (STEP_DIV   > 1) ? $clog2(STEP_DIV)   : 1;
  localparam int PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);
  localparam logic [PW-1:0] PWM_LAST = PW'(PWM_PERIOD - 1);

  logic [DW-1:0] r_div_cnt;
  logic [PW-1:0] r_pwm_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DW'(1);
      r_pwm_cnt <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + PW'(1);
    end
  end

  assign o_tick = (r_div_cnt == DIV_LAST);

  // Degenerate duties are resolved at elaboration so the compare never saturates.
  generate
    if (DIM_DUTY >= PWM_PERIOD) begin : g_dim_full
      assign o_dim = 1'b1;
    end else if (DIM_DUTY <= 0) begin : g_dim_off
      assign o_dim = 1'b0;
    end else begin : g_dim_pwm
      localparam logic [PW-1:0] DUTY = PW'(DIM_DUTY);
      assign o_dim = (r_pwm_cnt < DUTY);
    end
  endgenerate

endmodule

// File: rtl/dimmed_tail_lights.sv
// Thunderbird-style sequential turn signal with PWM-dimmed idle lamps.
// Define HAZARD_EN to make left&right in IDLE flash all six lamps.
module dimmed_tail_lights
  import tail_lights_pkg::*;
#(
  parameter int STEP_DIV   = 50_000_000,
  parameter int PWM_PERIOD = 16,
  parameter int DIM_DUTY   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                left,
  input  logic                right,
  output logic [N_LAMPS-1:0]  light
);

  state_t             r_state;
  state_t             w_next;
  logic               w_tick;
  logic               w_dim;
  logic [N_LAMPS-1:0] w_mask;
  logic [N_LAMPS-1:0] w_light_d;
  logic [N_LAMPS-1:0] r_light;

  tail_lights_timebase #(
    .STEP_DIV   (STEP_DIV),
    .PWM_PERIOD (PWM_PERIOD),
    .DIM_DUTY   (DIM_DUTY)
  ) u_timebase (
    .i_clk   (clk),
    .i_rst_n (reset),
    .o_tick  (w_tick),
    .o_dim   (w_dim)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Requests are only sampled in IDLE, so a started sweep always finishes.
  always_comb begin
    w_next = r_state;
    if (w_tick) begin
      case (r_state)
        IDLE: begin
          if (left && !right)      w_next = L1;
          else if (right && !left) w_next = R1;
`ifdef HAZARD_EN
          else if (left && right)  w_next = HAZ;
`endif
        end
        L1:      w_next = L2;
        L2:      w_next = L3;
        L3:      w_next = IDLE;
        R1:      w_next = R2;
        R2:      w_next = R3;
        R3:      w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_mask    = on_mask(r_state);
    w_light_d = w_mask | ({N_LAMPS{w_dim}} & ~w_mask);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_light <= '0;
    else        r_light <= w_light_d;
  end

  assign light = r_light;

endmodule

// File: tb/tb_dimmed_tail_lights.sv
// Directed plus randomized bench for dimmed_tail_lights with a queue-based lamp model.
module tb_dimmed_tail_lights;

  localparam int STEP_DIV   = 4;
  localparam int PWM_PERIOD = 4;
  localparam int DIM_DUTY   = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       left;
  logic       right;
  logic [5:0] light;

  int checks   = 0;
  int failures = 0;

  // Model: current lit mask, remaining sweep steps, idle flag, cycles since release.
  logic [5:0] m_mask = 6'b0;
  logic [5:0] m_seq_q[$];
  bit         m_idle = 1'b1;
  int         m_cnt  = 0;
  logic [5:0] m_exp  = 6'b0;

  dimmed_tail_lights #(
    .STEP_DIV   (STEP_DIV),
    .PWM_PERIOD (PWM_PERIOD),
    .DIM_DUTY   (DIM_DUTY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .left  (left),
    .right (right),
    .light (light)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s light=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mask = 6'b0;
    m_seq_q.delete();
    m_idle = 1'b1;
    m_cnt  = 0;
    m_exp  = 6'b0;
  endtask

  // Applies one clock edge of the reference behaviour.
  task automatic model_edge(input logic l, input logic r);
    bit glow;
    if (!reset) begin
      model_reset();
      return;
    end
    glow  = ((m_cnt % PWM_PERIOD) < DIM_DUTY);
    m_exp = m_mask | ({6{glow}} & ~m_mask);
    if ((m_cnt % STEP_DIV) == STEP_DIV - 1) begin
      if (m_idle) begin
        if (l && !r)      m_seq_q = '{6'b001000, 6'b011000, 6'b111000};
        else if (r && !l) m_seq_q = '{6'b000100, 6'b000110, 6'b000111};
`ifdef HAZARD_EN
        else if (l && r)  m_seq_q = '{6'b111111};
`endif
        if (m_seq_q.size() > 0) begin
          m_mask = m_seq_q.pop_front();
          m_idle = 1'b0;
        end
      end else if (m_seq_q.size() > 0) begin
        m_mask = m_seq_q.pop_front();
      end else begin
        m_mask = 6'b0;
        m_idle = 1'b1;
      end
    end
    m_cnt++;
  endtask

  // Called just after a negedge: drive, clock, update model, check.
  task automatic cycle(input logic l, input logic r, input string tag);
    left  = l;
    right = r;
    @(posedge clk);
    model_edge(l, r);
    #1;
    chk(tag, light, m_exp);
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] idle_pat[4];
    int guard;
    int seg_len;
    logic rl;
    logic rr;
    idle_pat = '{6'b111111, 6'b000000, 6'b000000, 6'b000000};

    reset = 1'b0;
    left  = 1'b0;
    right = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset held: lamps dark, ticks have no effect.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, "reset_hold");
      chk("reset_dark", light, 6'b000000);
    end

    // Release on a negedge; idle dims all lamps with period 4.
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, "idle_model");
      chk("idle_pattern", light, idle_pat[i % 4]);
    end

    // Held left request: repeated sweeps.
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, "left_sweep");

    // Switch to right while the left sweep is at step 2.
    guard = 0;
    while (m_mask != 6'b011000 && guard < 64) begin
      cycle(1'b1, 1'b0, "left_to_L2");
      guard++;
    end
    chk("reach_L2", (guard < 64) ? 6'b011000 : 6'b111111, 6'b011000);
    for (int i = 0; i < 36; i++) cycle(1'b0, 1'b1, "right_after_left");

    // Both held in idle.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, "drain");
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'b1, "both_held");
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, "drain2");

    // Asynchronous reset in the middle of L2.
    guard = 0;
    while (m_mask != 6'b011000 && guard < 64) begin
      cycle(1'b1, 1'b0, "left_to_L2b");
      guard++;
    end
    chk("reach_L2b", (guard < 64) ? 6'b011000 : 6'b111111, 6'b011000);
    @(posedge clk);
    model_edge(1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset", light, 6'b000000);
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, "reset_mid");
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, "restart_idle");
      chk("restart_pattern", light, idle_pat[i]);
    end
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, "restart_left");

    // Randomized request segments.
    for (int s = 0; s < 50; s++) begin
      seg_len = $urandom_range(1, 12);
      rl = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      for (int i = 0; i < seg_len; i++) cycle(rl, rr, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
